vmicro16_apb_arbiter: RTL and testbench
=======================================

# vmicro16_apb_arbiter

Shares the single SoC APB bus among `MASTER_PORTS` core masters and decodes the address to one of `SLAVE_PORTS` slave selects. It sits between the per-core APB master ports and the shared slave bus. It runs a round-robin grant, sequences the APB SETUP/ACCESS phases, routes the response back to the granted core only, and aborts hung transfers with an optional watchdog.

## Interface
- `MASTER_PORTS`, 2: number of requesting cores.
- `SLAVE_PORTS`, 5: number of slave selects.
- `BUS_WIDTH`, 16: PADDR/PWDATA/PRDATA width.
- `SEL_LSB`, 8: LSB of the slave-index field in PADDR. Field width is `SW = clog2(SLAVE_PORTS)`, min 1.
- `TIMEOUT`, 0: maximum ACCESS cycles before abort. 0 disables the watchdog.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `S_PADDR` in `MASTER_PORTS*BUS_WIDTH`: per-master address, packed; master i at `[i*BUS_WIDTH +: BUS_WIDTH]`.
- `S_PWRITE` in `MASTER_PORTS`: per-master write flag.
- `S_PSELx` in `MASTER_PORTS`: per-master request.
- `S_PENABLE` in `MASTER_PORTS`: ignored; the arbiter generates its own phases.
- `S_PWDATA` in `MASTER_PORTS*BUS_WIDTH`: per-master write data.
- `S_PRDATA` out `MASTER_PORTS*BUS_WIDTH`: per-master read data.
- `S_PREADY` out `MASTER_PORTS`: per-master completion.
- `M_PADDR` out `BUS_WIDTH`: shared bus address.
- `M_PWRITE` out 1: shared bus write flag.
- `M_PSELx` out `SLAVE_PORTS`: one-hot slave select.
- `M_PENABLE` out 1: shared bus enable.
- `M_PWDATA` out `BUS_WIDTH`: shared bus write data.
- `M_PRDATA` in `BUS_WIDTH`: read data from the selected slave.
- `M_PREADY` in 1: ready from the selected slave.
- `grant` out `clog2(MASTER_PORTS)`: index of the current or last granted master, for debug.
- `timeout_err` out 1: one-cycle pulse on watchdog abort.

## Operation
- **FSM states:** IDLE, SETUP, ACCESS.
- **IDLE:**
  - If any `S_PSELx` is high, pick the first requester at or after `rr_ptr`, wrapping modulo `MASTER_PORTS`.
  - Latch its index into `grant`.
  - Latch its PADDR, PWDATA and PWRITE into the `M_*` registers.
  - Go to SETUP.
- **SETUP:**
  - `M_PSELx[idx]=1`, where `idx = M_PADDR[SEL_LSB +: SW]`, provided `idx < SLAVE_PORTS`.
  - `M_PENABLE=0`.
  - Go to ACCESS.
- **ACCESS:**
  - `M_PSELx` held, `M_PENABLE=1`.
  - When `M_PREADY=1`:
    - `S_PREADY[grant]=1` and `S_PRDATA[grant]=M_PRDATA`, both combinational in the same cycle.
    - `rr_ptr <= grant+1`, wrapping.
    - Next state IDLE.
- **Decode miss** (`idx >= SLAVE_PORTS`):
  - `M_PSELx` stays all-zero.
  - In the first ACCESS cycle the arbiter completes the transfer itself: `S_PREADY[grant]=1`, `S_PRDATA[grant]=0`, writes dropped.
- **Watchdog** (`TIMEOUT>0`):
  - `wd_cnt` clears on entry to ACCESS and increments every ACCESS cycle with `M_PREADY=0`.
  - When `wd_cnt==TIMEOUT-1` and `M_PREADY=0`, abort:
    - `S_PREADY[grant]=1`, `S_PRDATA[grant]` all ones.
    - `timeout_err=1`.
    - Next state IDLE with `M_PSELx`/`M_PENABLE` deasserted.
  - `M_PREADY` in the same cycle wins; that completes as normal with no error.
- **Routing rules:**
  - Non-granted masters always see `S_PREADY=0` and `S_PRDATA=0`.
  - Outside ACCESS, every `S_PREADY` and `S_PRDATA` is 0.
- **Granted master drops `S_PSELx` mid-transfer:** this is a protocol violation. The transfer still completes on the bus; the response is routed but ignored.
- **Simultaneous requests:** exactly one grant per IDLE cycle. The others hold their `S_PSELx` and wait.

## Timing
- **Reset (async):**
  - State IDLE, `rr_ptr=0`, `grant=0`, `wd_cnt=0`.
  - All `M_*` outputs 0.
  - All `S_PREADY`/`S_PRDATA` 0, `timeout_err=0`.
  - Takes effect immediately, including mid-transfer; no completion is signalled to the master.
- **Latency:** a request seen in IDLE at cycle 0 gives SETUP in cycle 1 and ACCESS in cycle 2. With a zero-wait slave, `S_PREADY` is high in cycle 2.
- **Throughput:** one mandatory IDLE cycle between transfers, so a transfer takes at least 3 cycles.
- **Registered vs combinational:** `M_PADDR`, `M_PWDATA` and `M_PWRITE` are registered and stable from SETUP through the end of ACCESS. `M_PSELx` and `M_PENABLE` decode from the state register.
- `timeout_err` is combinational and high only in the abort cycle.

## Structure
- **Shared header `vmicro16_apb_defs`:**
  - FSM state encodings (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2).
  - `clog2` function.
  - Timeout read-data constant (all ones).
- **Sub-module `vmicro16_rr_arbiter`:**
  - Inputs: `req[MASTER_PORTS]`, `ptr`.
  - Outputs: `valid`, `idx`.
  - Purely combinational rotate-priority pick, reusable by later bus blocks.
- The FSM, address decode, watchdog and response routing live in `vmicro16_apb_arbiter`.

## Test plan
- **Single master, zero wait:** master 0 writes 0x1234 to PADDR 0x0400. Slave 4 sees PSEL in cycles 1-2 and PENABLE in cycle 2; `S_PREADY[0]` rises in cycle 2.
- **Contention, round-robin:** masters 0 and 1 both hold requests continuously for 4 transfers. Grants go 0,1,0,1; each transfer spans 3 cycles.
- **Wait states and read data:** slave holds `M_PREADY` low for 3 ACCESS cycles, then returns 0xBEEF. Master 1 receives 0xBEEF exactly in the ready cycle; master 0 sees 0.
- **Decode miss:** PADDR 0x0700 with `SLAVE_PORTS=5`. No `M_PSELx` asserts; `S_PREADY` is high in the first ACCESS cycle with `PRDATA=0`.
- **Watchdog:** `TIMEOUT=4`, slave never ready. Abort in the 4th ACCESS cycle with `PRDATA=0xFFFF` and a 1-cycle `timeout_err`. The next requester is granted afterwards.
- **Reset mid-ACCESS:** assert `reset` during a wait-state transfer. All outputs go to 0 without a clock edge; after release, master 0 has first priority.

Source files
------------

// File: rtl/vmicro16_apb_arbiter_pkg.sv
// Shared APB definitions for the vmicro16 bus blocks: FSM encodings,
// a log2 helper and the read-data value returned on a watchdog abort.
package vmicro16_apb_defs;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_e;

    localparam logic [63:0] TIMEOUT_RDATA = '1;

    // Ceiling log2, never less than 1 so it can size a vector directly.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/vmicro16_apb_arbiter_rr.sv
// Combinational rotate-priority picker: first requester at or after ptr,
// wrapping modulo N.
module vmicro16_rr_arbiter
    import vmicro16_apb_defs::*;
#(
    parameter  int N  = 2,
    localparam int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Walk the candidates from farthest to nearest so the nearest one wins.
    always_comb begin
        // NOTE: every output gets a default before any branch, otherwise an
        // incomplete path in always_comb infers a latch.
        valid = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                valid = 1'b1;
                idx   = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/vmicro16_apb_arbiter.sv
// Multi-master to single APB bus bridge: round-robin grant, SETUP/ACCESS
// sequencing, slave-select decode, response routing and optional watchdog.
module vmicro16_apb_arbiter
    import vmicro16_apb_defs::*;
#(
    parameter  int MASTER_PORTS = 2,
    parameter  int SLAVE_PORTS  = 5,
    parameter  int BUS_WIDTH    = 16,
    parameter  int SEL_LSB      = 8,
    parameter  int TIMEOUT      = 0,
    localparam int SW           = clog2(SLAVE_PORTS),
    localparam int GW           = clog2(MASTER_PORTS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR,
    input  logic [MASTER_PORTS-1:0]        S_PWRITE,
    input  logic [MASTER_PORTS-1:0]        S_PSELx,
    input  logic [MASTER_PORTS-1:0]        S_PENABLE,
    input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA,
    output logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA,
    output logic [MASTER_PORTS-1:0]        S_PREADY,
    output logic [BUS_WIDTH-1:0]           M_PADDR,
    output logic                           M_PWRITE,
    output logic [SLAVE_PORTS-1:0]         M_PSELx,
    output logic                           M_PENABLE,
    output logic [BUS_WIDTH-1:0]           M_PWDATA,
    input  logic [BUS_WIDTH-1:0]           M_PRDATA,
    input  logic                           M_PREADY,
    output logic [GW-1:0]                  grant,
    output logic                           timeout_err
);

    localparam int WD_W = clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    apb_state_e           state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
    logic [BUS_WIDTH-1:0] paddr_q, paddr_d;
    logic [BUS_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                 pwrite_q, pwrite_d;

    logic                 pick_valid;
    logic [GW-1:0]        pick_idx;
    logic [SW-1:0]        slave_idx;
    logic                 slave_hit;
    logic                 bus_active;
    logic                 rsp_valid;
    logic [BUS_WIDTH-1:0] rsp_data;
    logic [GW-1:0]        grant_next;
    logic                 unused_penable;

    // Masters' own enable phase is meaningless here; phases are regenerated.
    assign unused_penable = ^S_PENABLE;

    vmicro16_rr_arbiter #(.N(MASTER_PORTS)) u_rr (
        .req   (S_PSELx),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign slave_idx  = paddr_q[SEL_LSB +: SW];
    assign slave_hit  = int'(slave_idx) < SLAVE_PORTS;
    assign bus_active = (state_q == APB_SETUP) || (state_q == APB_ACCESS);
    assign grant_next = (grant_q == GW'(MASTER_PORTS - 1)) ? '0 : grant_q + GW'(1);

    assign M_PADDR   = paddr_q;
    assign M_PWDATA  = pwdata_q;
    assign M_PWRITE  = pwrite_q;
    assign M_PENABLE = (state_q == APB_ACCESS);
    assign grant     = grant_q;

    always_comb begin
        M_PSELx = '0;
        for (int s = 0; s < SLAVE_PORTS; s++) begin
            M_PSELx[s] = bus_active && slave_hit && (slave_idx == SW'(s));
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        wd_cnt_d    = wd_cnt_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        timeout_err = 1'b0;
        unique case (state_q)
            APB_IDLE: begin
                if (pick_valid) begin
                    grant_d  = pick_idx;
                    paddr_d  = S_PADDR[int'(pick_idx)*BUS_WIDTH +: BUS_WIDTH];
                    pwdata_d = S_PWDATA[int'(pick_idx)*BUS_WIDTH +: BUS_WIDTH];
                    pwrite_d = S_PWRITE[pick_idx];
                    state_d  = APB_SETUP;
                end
            end
            APB_SETUP: begin
                wd_cnt_d = '0;
                state_d  = APB_ACCESS;
            end
            APB_ACCESS: begin
                // A decode miss is answered locally with zero data; writes vanish.
                if (!slave_hit) begin
                    rsp_valid = 1'b1;
                end else if (M_PREADY) begin
                    rsp_valid = 1'b1;
                    rsp_data  = M_PRDATA;
                end else if (TIMEOUT > 0 && wd_cnt_q == WD_LAST) begin
                    rsp_valid   = 1'b1;
                    rsp_data    = BUS_WIDTH'(TIMEOUT_RDATA);
                    timeout_err = 1'b1;
                end else if (TIMEOUT > 0) begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
                if (rsp_valid) begin
                    rr_ptr_d = grant_next;
                    state_d  = APB_IDLE;
                end
            end
            default: state_d = APB_IDLE;
        endcase
    end

    // Only the granted master ever sees a response; everyone else reads zero.
    always_comb begin
        S_PREADY = '0;
        S_PRDATA = '0;
        if (rsp_valid) begin
            S_PREADY[grant_q] = 1'b1;
            S_PRDATA[int'(grant_q)*BUS_WIDTH +: BUS_WIDTH] = rsp_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q  <= APB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            wd_cnt_q <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            wd_cnt_q <= wd_cnt_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
        end
    end

endmodule

// File: tb/tb_vmicro16_apb_arbiter.sv
// Self-checking bench for vmicro16_apb_arbiter: directed vector table,
// hand-written contention/watchdog/reset sequences and randomized traffic.
module tb_vmicro16_apb_arbiter;

    localparam int NM = 2;
    localparam int NS = 5;
    localparam int BW = 16;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NM*BW-1:0]  s_paddr, s_pwdata, s_prdata;
    logic [NM-1:0]     s_pwrite, s_psel, s_penable, s_pready;
    logic [BW-1:0]     m_paddr, m_pwdata, m_prdata;
    logic              m_pwrite, m_penable, m_pready;
    logic [NS-1:0]     m_psel;
    logic [0:0]        grant;
    logic              timeout_err;

    vmicro16_apb_arbiter #(
        .MASTER_PORTS(NM), .SLAVE_PORTS(NS), .BUS_WIDTH(BW), .SEL_LSB(8), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .S_PADDR(s_paddr), .S_PWRITE(s_pwrite), .S_PSELx(s_psel), .S_PENABLE(s_penable),
        .S_PWDATA(s_pwdata), .S_PRDATA(s_prdata), .S_PREADY(s_pready),
        .M_PADDR(m_paddr), .M_PWRITE(m_pwrite), .M_PSELx(m_psel), .M_PENABLE(m_penable),
        .M_PWDATA(m_pwdata), .M_PRDATA(m_prdata), .M_PREADY(m_pready),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural view of the masters and the round-robin pointer.
    int          rr = 0;
    logic        pend[NM];
    logic [BW-1:0] p_addr[NM];
    logic [BW-1:0] p_wdata[NM];
    logic        p_wr[NM];

    typedef struct {
        int          m;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        wr;
        int          waits;
        logic [15:0] rdata;
        logic [4:0]  exp_sel;
        int          exp_len;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_reqs();
        for (int m = 0; m < NM; m++) begin
            s_psel[m]            = pend[m];
            s_paddr[m*BW +: BW]  = p_addr[m];
            s_pwdata[m*BW +: BW] = p_wdata[m];
            s_pwrite[m]          = p_wr[m];
        end
        s_penable = NM'($urandom);
    endtask

    task automatic set_req(input int m, input logic [BW-1:0] a, input logic [BW-1:0] d, input logic w);
        pend[m]    = 1'b1;
        p_addr[m]  = a;
        p_wdata[m] = d;
        p_wr[m]    = w;
    endtask

    function automatic int model_pick();
        int c;
        for (int k = 0; k < NM; k++) begin
            c = (rr + k) % NM;
            if (pend[c]) return c;
        end
        return 0;
    endfunction

    function automatic logic [NS-1:0] model_sel(input logic [BW-1:0] a);
        logic [NS-1:0] r;
        int i;
        r = '0;
        i = int'(a[10:8]);
        if (i < NS) r[i] = 1'b1;
        return r;
    endfunction

    // Entered at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
    task automatic do_transfer(input string tag, input int g, input int waits,
                               input logic [BW-1:0] rdata, input logic [NS-1:0] exp_sel,
                               input int exp_len, input logic [BW-1:0] exp_data,
                               input logic exp_err, output int done_cyc);
        logic [NM*BW-1:0] exp_prd;
        logic [NM-1:0]    exp_rdy;
        logic             last;
        done_cyc = -1;
        m_pready = 1'b0;
        apply_reqs();
        @(negedge clk);
        check({tag, " idle psel"}, m_psel, 0);
        check({tag, " idle pready"}, s_pready, 0);
        check({tag, " idle prdata"}, s_prdata, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, " setup grant"}, grant, g);
        check({tag, " setup paddr"}, m_paddr, p_addr[g]);
        check({tag, " setup pwdata"}, m_pwdata, p_wdata[g]);
        check({tag, " setup pwrite"}, m_pwrite, p_wr[g]);
        check({tag, " setup psel"}, m_psel, exp_sel);
        check({tag, " setup penable"}, m_penable, 0);
        check({tag, " setup pready"}, s_pready, 0);
        for (int k = 0; k < exp_len; k++) begin
            @(posedge clk); #1;
            m_pready = (k == waits);
            m_prdata = (k == waits) ? rdata : BW'($urandom);
            @(negedge clk);
            last    = (k == exp_len - 1);
            exp_rdy = '0;
            exp_prd = '0;
            if (last) begin
                exp_rdy[g]          = 1'b1;
                exp_prd[g*BW +: BW] = exp_data;
                done_cyc            = cyc;
            end
            check({tag, " access psel"}, m_psel, exp_sel);
            check({tag, " access penable"}, m_penable, 1);
            check({tag, " access paddr"}, m_paddr, p_addr[g]);
            check({tag, " access pready"}, s_pready, exp_rdy);
            check({tag, " access prdata"}, s_prdata, exp_prd);
            check({tag, " access timeout_err"}, timeout_err, last && exp_err);
        end
        @(posedge clk); #1;
        m_pready = 1'b0;
        pend[g]  = 1'b0;
        rr       = (g + 1) % NM;
        apply_reqs();
        check({tag, " after psel"}, m_psel, 0);
        check({tag, " after penable"}, m_penable, 0);
        check({tag, " after timeout_err"}, timeout_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_time_limit: got expired expected finish");
        $fatal(1);
    end

    initial begin
        int dc, prev, g, waits, len;
        logic [BW-1:0] rd, edata, addr;
        logic [NS-1:0] esel;
        logic          eerr;
        int exp_g[4];

        vecs[0] = '{0, 16'h0400, 16'h1234, 1'b1, 0,  16'h0000, 5'b10000, 1, 16'h0000, 1'b0};
        vecs[1] = '{1, 16'h0100, 16'h0000, 1'b0, 3,  16'hBEEF, 5'b00010, 4, 16'hBEEF, 1'b0};
        vecs[2] = '{0, 16'h0700, 16'h5A5A, 1'b1, 0,  16'h5555, 5'b00000, 1, 16'h0000, 1'b0};
        vecs[3] = '{1, 16'h0200, 16'h0000, 1'b0, 10, 16'h0000, 5'b00100, 4, 16'hFFFF, 1'b1};
        vecs[4] = '{0, 16'h0000, 16'h0000, 1'b0, 1,  16'h0A5A, 5'b00001, 2, 16'h0A5A, 1'b0};
        vecs[5] = '{1, 16'h0312, 16'h0000, 1'b0, 3,  16'h1357, 5'b01000, 4, 16'h1357, 1'b0};
        vecs[6] = '{0, 16'h0500, 16'h0000, 1'b0, 0,  16'h7777, 5'b00000, 1, 16'h0000, 1'b0};
        exp_g = '{0, 1, 0, 1};

        reset = 1'b1;
        m_pready = 1'b0;
        m_prdata = '0;
        for (int m = 0; m < NM; m++) begin
            pend[m] = 1'b0; p_addr[m] = '0; p_wdata[m] = '0; p_wr[m] = 1'b0;
        end
        apply_reqs();
        #1;
        check("reset paddr", m_paddr, 0);
        check("reset psel", m_psel, 0);
        check("reset penable", m_penable, 0);
        check("reset pwrite", m_pwrite, 0);
        check("reset grant", grant, 0);
        check("reset pready", s_pready, 0);
        check("reset timeout_err", timeout_err, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Both masters keep requesting: grants must alternate, 3 cycles each.
        set_req(0, 16'h0100, 16'hA000, 1'b1);
        set_req(1, 16'h0200, 16'hB000, 1'b1);
        prev = 0;
        for (int t = 0; t < 4; t++) begin
            g  = exp_g[t];
            rd = BW'($urandom);
            do_transfer($sformatf("rr%0d", t), g, 0, rd, model_sel(p_addr[g]), 1, rd, 1'b0, dc);
            pend[g] = 1'b1;
            apply_reqs();
            if (t > 0) check($sformatf("rr%0d span", t), dc - prev, 3);
            prev = dc;
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;

        for (int i = 0; i < 7; i++) begin
            pend[0] = 1'b0;
            pend[1] = 1'b0;
            set_req(vecs[i].m, vecs[i].addr, vecs[i].wdata, vecs[i].wr);
            do_transfer($sformatf("vec%0d", i), vecs[i].m, vecs[i].waits, vecs[i].rdata,
                        vecs[i].exp_sel, vecs[i].exp_len, vecs[i].exp_data, vecs[i].exp_err, dc);
        end

        // Watchdog abort on master 1, then the waiting master 0 takes the bus.
        set_req(1, 16'h0300, 16'h0000, 1'b0);
        set_req(0, 16'h0400, 16'h0000, 1'b0);
        do_transfer("wd", 1, 10, 16'h0000, 5'b01000, 4, 16'hFFFF, 1'b1, dc);
        do_transfer("after wd", 0, 0, 16'h2222, 5'b10000, 1, 16'h2222, 1'b0, dc);

        for (int it = 0; it < 60; it++) begin
            for (int m = 0; m < NM; m++) begin
                if (!pend[m] && $urandom_range(1, 0) == 1) begin
                    addr = {5'($urandom), 3'($urandom), 8'($urandom)};
                    set_req(m, addr, BW'($urandom), 1'($urandom));
                end
            end
            if (!pend[0] && !pend[1]) set_req(it % NM, 16'h0100, 16'h0001, 1'b1);
            g     = model_pick();
            waits = $urandom_range(5, 0);
            rd    = BW'($urandom);
            esel  = model_sel(p_addr[g]);
            if (esel == '0) begin
                len = 1; edata = '0; eerr = 1'b0;
            end else if (waits + 1 <= TO) begin
                len = waits + 1; edata = rd; eerr = 1'b0;
            end else begin
                len = TO; edata = '1; eerr = 1'b1;
            end
            do_transfer($sformatf("rand%0d", it), g, waits, rd, esel, len, edata, eerr, dc);
        end

        // Reset in the middle of a waiting ACCESS phase.
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        set_req(1, 16'h0100, 16'h4444, 1'b1);
        apply_reqs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_pready = 1'b0;
        check("rst pre penable", m_penable, 1);
        #2;
        reset = 1'b1;
        #1;
        check("rst paddr", m_paddr, 0);
        check("rst pwdata", m_pwdata, 0);
        check("rst pwrite", m_pwrite, 0);
        check("rst psel", m_psel, 0);
        check("rst penable", m_penable, 0);
        check("rst pready", s_pready, 0);
        check("rst prdata", s_prdata, 0);
        check("rst grant", grant, 0);
        check("rst timeout_err", timeout_err, 0);
        pend[1] = 1'b0;
        apply_reqs();
        @(negedge clk);
        reset = 1'b0;
        rr    = 0;
        @(posedge clk); #1;
        set_req(0, 16'h0000, 16'h0F0F, 1'b1);
        set_req(1, 16'h0100, 16'h4444, 1'b1);
        do_transfer("post rst m0", 0, 0, 16'h3333, 5'b00001, 1, 16'h3333, 1'b0, dc);
        do_transfer("post rst m1", 1, 1, 16'h6666, 5'b00010, 2, 16'h6666, 1'b0, dc);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
